// File: rtl/logits_requant.sv
// Requantises the ten final-layer accumulators into a signed DATA_WIDTH vector and hands it to the classifier.
// Packed buses are [0:9] ordered: element 0 occupies the most significant slice of bias and matrix.
module logits_requant #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int NUM_CLASSES = 10,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ACC_WIDTH-1:0]              in_data,
    input  logic                              in_last,
    input  logic [NUM_CLASSES*ACC_WIDTH-1:0]  bias,
    input  logic [SHIFT_WIDTH-1:0]            shift,
    output logic [NUM_CLASSES*DATA_WIDTH-1:0] matrix,
    output logic                              start,
    input  logic                              cls_ready,
    output logic                              err,
    output logic                              busy
);

    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam int SUM_W = ACC_WIDTH + 2;
    localparam int RND_W = SUM_W + 1;
    localparam int MAX_I = 2 ** (DATA_WIDTH - 1) - 1;
    localparam int MIN_I = -(2 ** (DATA_WIDTH - 1));
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'(MAX_I);
    localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(MIN_I);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_START, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;

    logic                    s1_valid_q;
    logic [IDX_W-1:0]        s1_idx_q;
    logic [SHIFT_WIDTH-1:0]  s1_shift_q;
    logic signed [SUM_W-1:0] s1_sum_q;

    logic                    beat_fire;
    logic                    is_last_idx;
    logic                    frame_ok;
    logic                    frame_bad;
    logic [ACC_WIDTH-1:0]    bias_arr [NUM_CLASSES];
    logic [ACC_WIDTH-1:0]    bias_sel;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [RND_W-1:0] half;
    logic signed [RND_W-1:0] rnd_in;
    logic signed [RND_W-1:0] shifted;
    logic [DATA_WIDTH-1:0]   sat;

    assign beat_fire   = in_valid && in_ready;
    assign is_last_idx = (idx_q == LAST_IDX);
    assign frame_ok    = beat_fire && in_last && is_last_idx;
    assign frame_bad   = beat_fire && (in_last != is_last_idx);

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : gen_bias
        assign bias_arr[gi] = bias[(NUM_CLASSES-1-gi)*ACC_WIDTH +: ACC_WIDTH];
    end

    assign bias_sel = bias_arr[idx_q];
    // Two guard bits so accumulator + bias can never wrap before saturation.
    assign sum_d = {{2{in_data[ACC_WIDTH-1]}}, in_data} + {{2{bias_sel[ACC_WIDTH-1]}}, bias_sel};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (beat_fire) begin
                    if (frame_ok) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end else if (frame_bad) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN:  if (!s1_valid_q) state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT:   if (cls_ready) state_d = S_COLLECT;
            default:  state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_COLLECT);
        start    = (state_q == S_START);
        busy     = (state_q != S_COLLECT) || (idx_q != '0) || s1_valid_q;
        err      = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_shift_q <= '0;
            s1_sum_q   <= '0;
        end else begin
            s1_valid_q <= beat_fire;
            if (beat_fire) begin
                s1_idx_q   <= idx_q;
                s1_shift_q <= shift;
                s1_sum_q   <= sum_d;
            end
        end
    end

    // Round half up: add half an LSB of the output before the arithmetic shift.
    always_comb begin
        half = '0;
        if (s1_shift_q != '0) begin
            half = {{(RND_W-1){1'b0}}, 1'b1} << (s1_shift_q - 1'b1);
        end
        rnd_in  = {s1_sum_q[SUM_W-1], s1_sum_q} + half;
        shifted = rnd_in >>> s1_shift_q;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat = shifted[DATA_WIDTH-1:0];
        end
    end

    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : gen_elem
        logic [DATA_WIDTH-1:0] elem_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                elem_q <= '0;
            end else if (s1_valid_q && (s1_idx_q == IDX_W'(gi))) begin
                elem_q <= sat;
            end
        end
        assign matrix[(NUM_CLASSES-1-gi)*DATA_WIDTH +: DATA_WIDTH] = elem_q;
    end

endmodule

// File: tb/tb_logits_requant.sv
// Randomised self-checking bench for logits_requant against an arithmetic reference model.
module tb_logits_requant;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NC = 10;
    localparam int SW = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_data;
    logic             in_last;
    logic [NC*AW-1:0] bias;
    logic [SW-1:0]    shift;
    logic [NC*DW-1:0] matrix;
    logic             start;
    logic             cls_ready;
    logic             err;
    logic             busy;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     vec_data  [NC];
    int     vec_bias  [NC];
    int     vec_shift [NC];
    longint exp_mat   [NC];

    always #5 clk = ~clk;

    logits_requant #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .NUM_CLASSES(NC),
        .SHIFT_WIDTH(SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .bias     (bias),
        .shift    (shift),
        .matrix   (matrix),
        .start    (start),
        .cls_ready(cls_ready),
        .err      (err),
        .busy     (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output element i of the packed result, element 0 in the top slice.
    function automatic longint el(input int i);
        logic [DW-1:0] b;
        b = matrix[(NC-1-i)*DW +: DW];
        return longint'($signed(b));
    endfunction

    // Reference: exact integer sum, floor((sum + d/2) / d) with d = 2^shift, then clamp.
    function automatic longint ref_val(input int d, input int b, input int sh);
        longint s, num, den, q;
        s = longint'(d) + longint'(b);
        if (sh == 0) begin
            q = s;
        end else begin
            den = longint'(1) << sh;
            num = s + den / 2;
            q   = num / den;
            if ((num % den) != 0 && num < 0) q = q - 1;
        end
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic check_matrix(input string tag);
        for (int i = 0; i < NC; i++) check(tag, el(i), exp_mat[i]);
    endtask

    task automatic rand_vector;
        for (int i = 0; i < NC; i++) begin
            case ($urandom_range(0, 2))
                0:       vec_data[i] = int'($urandom_range(0, 600)) - 300;
                1:       vec_data[i] = int'($urandom);
                default: vec_data[i] = int'($urandom_range(0, 200000)) - 100000;
            endcase
            vec_bias[i]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1000)) - 500
                                                        : int'($urandom);
            vec_shift[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                        : int'($urandom_range(0, 10));
        end
    endtask

    task automatic send_beats(input int nbeats, input int last_at);
        for (int i = 0; i < NC; i++) bias[(NC-1-i)*AW +: AW] = vec_bias[i];
        cls_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            in_valid = 1'b1;
            in_data  = vec_data[i];
            in_last  = (i == last_at);
            shift    = SW'(vec_shift[i]);
            check("beat_in_ready", in_ready, 1);
            exp_mat[i] = ref_val(vec_data[i], vec_bias[i], vec_shift[i]);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called in the cycle after the final beat; start is due three cycles after that beat.
    task automatic observe(input bit exp_start, input bit exp_err);
        for (int c = 1; c <= 6; c++) begin
            check("err_pulse", err, (c == 1) && exp_err);
            check("start_pulse", start, (c == 3) && exp_start);
            check("drain_in_ready", in_ready, exp_start ? 0 : 1);
            if (c == 3 && exp_start) check_matrix("start_matrix");
            tick();
        end
    endtask

    task automatic handshake(input int hold);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
            check("wait_in_ready", in_ready, 0);
            check("wait_busy", busy, 1);
            check_matrix("wait_matrix");
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        cls_ready = 1'b1;
        check("wait_in_ready", in_ready, 0);
        tick();
        check("release_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        bias      = '0;
        shift     = '0;
        cls_ready = 1'b0;
        for (int i = 0; i < NC; i++) exp_mat[i] = 0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_start", start, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check_matrix("reset_matrix");
        reset = 1'b0;
        tick();

        // Ramp 0..9, no bias, no shift.
        for (int i = 0; i < NC; i++) begin
            vec_data[i]  = i;
            vec_bias[i]  = 0;
            vec_shift[i] = 0;
        end
        send_beats(NC, NC - 1);
        observe(1, 0);
        for (int i = 0; i < NC; i++) check("ramp_value", el(i), i);
        handshake(3);

        // Rounding and saturation corners, then a long classifier hold.
        rand_vector();
        vec_data[0] = 5;                  vec_bias[0] = 2;  vec_shift[0] = 2;
        vec_data[1] = -7;                 vec_bias[1] = 0;  vec_shift[1] = 1;
        vec_data[2] = 1000;               vec_bias[2] = 0;  vec_shift[2] = 0;
        vec_data[3] = -1000;              vec_bias[3] = 0;  vec_shift[3] = 0;
        vec_data[4] = int'(32'h7FFFFFFF); vec_bias[4] = 1;  vec_shift[4] = 0;
        vec_data[5] = int'(32'h80000000); vec_bias[5] = -1; vec_shift[5] = 0;
        send_beats(NC, NC - 1);
        observe(1, 0);
        check("round_pos", el(0), 2);
        check("round_neg", el(1), -3);
        check("sat_pos", el(2), 127);
        check("sat_neg", el(3), -128);
        check("sat_nowrap_pos", el(4), 127);
        check("sat_nowrap_neg", el(5), -128);
        handshake(20);

        // in_last on the 4th beat, then a clean vector.
        rand_vector();
        send_beats(4, 3);
        observe(0, 1);
        check("early_last_busy", busy, 0);
        rand_vector();
        send_beats(NC, NC - 1);
        observe(1, 0);
        handshake(2);

        // 10th beat without in_last.
        rand_vector();
        send_beats(NC, -1);
        observe(0, 1);
        check("missing_last_busy", busy, 0);

        // Asynchronous reset after the 6th beat.
        rand_vector();
        send_beats(6, -1);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NC; i++) exp_mat[i] = 0;
        check_matrix("async_reset_matrix");
        check("async_reset_start", start, 0);
        check("async_reset_err", err, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("post_reset_start", start, 0);
        rand_vector();
        send_beats(NC, NC - 1);
        observe(1, 0);
        handshake(1);

        // Randomised vectors.
        for (int v = 0; v < 10; v++) begin
            rand_vector();
            send_beats(NC, NC - 1);
            observe(1, 0);
            handshake(int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logits_requant.md
Name: logits_requant

Overview:
- Upstream neighbour of the argmax/classifier stage.
- Collects the 10 wide signed accumulator results of the final dense layer, streamed one per beat from the systolic array drain.
- Per beat: adds a per-class bias, arithmetic-right-shifts with rounding, and saturates to DATA_WIDTH.
- Packs the results into a 10-element vector, pulses start to the classifier, then holds the vector stable until the classifier reports ready.

Parameters:
DATA_WIDTH, 8, width of each signed output element
ACC_WIDTH, 32, width of each signed input accumulator and bias
NUM_CLASSES, 10, elements per vector (fixed at 10 for the classifier)
SHIFT_WIDTH, 5, width of the requant shift amount

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid && in_ready
in_data  input  ACC_WIDTH  signed accumulator for class = current index
in_last  input  1  marks the final (10th) beat of a vector
bias  input  NUM_CLASSES*ACC_WIDTH  packed signed per-class bias, [0:9] order, static during a vector
shift  input  SHIFT_WIDTH  right-shift amount, sampled with each accepted beat
matrix  output  NUM_CLASSES*DATA_WIDTH  packed signed results, [0:9] order, registered
start  output  1  one-cycle pulse, vector valid
cls_ready  input  1  classifier done; held high after completion until its next start
err  output  1  one-cycle pulse on a framing error
busy  output  1  high in any state other than COLLECT with idx==0 and pipeline empty

Behaviour:
- Reset (asynchronous, any cycle, including mid-vector): state=COLLECT, idx=0, pipeline valids=0, matrix=0, start=0, err=0. Any partial vector is discarded.
- State COLLECT: in_ready=1. Each accepted beat enters stage 1 tagged with idx, then idx increments.
  - Accepted beat with idx==9 and in_last=1: go to DRAIN.
  - Beat with in_last=1 and idx!=9, or idx==9 with in_last=0: err pulses the next cycle, idx returns to 0, the vector is dropped and no start is issued. In-flight pipeline writes for the dropped vector still land in matrix.
- Stage 1 (registered): sum = sign-extended in_data + bias[idx], computed at ACC_WIDTH+2 bits. Beat index and shift are carried along.
- Stage 2 (registered write into matrix[idx]):
  - if shift==0, r = sum;
  - else r = (sum + (1 << (shift-1))) >>> shift, which is round-half-up.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- State DRAIN: in_ready=0. Wait until both pipeline stages are empty, then go to START.
- State START: start=1 for exactly one cycle, then go to WAIT.
  - Latency: last beat accepted in cycle L gives matrix complete at the end of L+2 and start high in cycle L+3.
- State WAIT: in_ready=0, matrix frozen. Go to COLLECT in the cycle after cls_ready is sampled high.
  - WAIT is entered one cycle after start, so the classifier's stale ready has already been cleared.
- matrix changes only through stage-2 writes. It is stable from the start cycle until WAIT exits.
- No back-pressure is applied inside a vector. in_ready drops only in DRAIN, START and WAIT.
- Simultaneous reset and any event: reset wins.

Test Plan:
- Bias=0, shift=0, in_data = 0..9 with in_last on the 10th beat, cls_ready pulsed later -> matrix={0,1,..,9}, start exactly 3 cycles after the last beat, one pulse only.
- Rounding: in_data=5, bias=2, shift=2 -> (7+2)>>>2 = 2; in_data=-7, bias=0, shift=1 -> (-7+1)>>>1 = -3.
- Saturation, DATA_WIDTH=8, shift=0: in_data=1000 -> 127; in_data=-1000 -> -128; in_data=0x7FFFFFFF with bias=1 -> 127, with no wrap.
- Framing error:
  - in_last on the 4th beat -> err pulses, no start, next 10-beat vector is accepted normally.
  - 10th beat without in_last -> err pulses.
- Handshake: with cls_ready held low for 20 cycles after start, in_valid high gives in_ready=0 and an unchanged matrix. When cls_ready rises, in_ready=1 on the following cycle.
- Assert reset asynchronously after the 6th beat -> outputs are 0 immediately, no start. A fresh 10-beat vector then completes correctly.
